mac_rx_frame_writer: RTL

Sits between the tri-mode MAC receive FIFO interface and the frame buffer RAM that the AXI4-Lite read slave serves, in the MAC clock domain. Pulls received words from the MAC with the data-available / read-request handshake. Packs each frame into a circular word buffer as a length header followed by payload. Publishes a committed write pointer only after a frame is complete. Frames that overflow the buffer, exceed the length limit, or are truncated are rolled back and never become visible downstream.

---
 rtl/mac_rx_wr_pkg.sv | 22 ++
 rtl/mac_rx_frame_writer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_rx_wr_pkg.sv
// Shared definitions for the MAC receive frame writer.
//   state_t       : writer FSM states (IDLE, RECV, HDR, DROP)
//   HDR_LEN_LSB/MSB: bit positions of the byte-length field in the header word
//   ben_to_bytes  : converts the MAC end-of-packet byte enable to a byte count
package mac_rx_wr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        HDR  = 2'd2,
        DROP = 2'd3
    } state_t;

    localparam int HDR_LEN_LSB = 0;
    localparam int HDR_LEN_MSB = 15;

    // 00 means a full word; otherwise the code is the byte count itself.
    function automatic logic [15:0] ben_to_bytes(input logic [1:0] ben);
        return (ben == 2'b00) ? 16'd4 : {14'd0, ben};
    endfunction

endpackage

// File: rtl/mac_rx_frame_writer.sv
// mac_rx_frame_writer
// Pulls received words from the MAC FIFO and packs each frame into a circular
// word buffer as [length header][payload ...]. The write pointer seen by the
// consumer only moves once a frame is complete; overflowing, over-long and
// truncated frames are rolled back and never become visible.
//
// Ports (all in the mac_clk_i domain, every output registered):
//   mac_clk_i, mac_rst_i     clock, synchronous active-high reset
//   mac_rxda_i               MAC FIFO holds at least one frame
//   mac_rxrqrd_o             read request to the MAC
//   mac_rxd_i, mac_ben_i     receive word and eop byte enable (00=4,01=1,10=2,11=3)
//   mac_rxsop_i/mac_rxeop_i  frame delimiters, qualified by mac_rxdv_i
//   mac_rxdv_i               receive word valid
//   buf_we_o/buf_waddr_o/buf_wdata_o  frame buffer RAM write port
//   buf_rd_ptr_i             consumer read pointer (already in this domain)
//   buf_wr_ptr_o             committed write pointer (next free header slot)
//   frm_done_o / frm_drop_o  one-cycle pulse per committed / discarded frame
//   dbg_state_o              current FSM state, for observation
//   drop_cnt_o               saturating drop counter, only when the macro
//                            MAC_RX_WR_DROP_CNT_EN is defined
//
// Handshake: the MAC presents a word by raising mac_rxdv_i; a word is
// consumed in every cycle mac_rxdv_i is high. mac_rxrqrd_o asks the MAC for
// words and is high in IDLE (when a frame is waiting and there is room for at
// least header + one word), throughout RECV and DROP, and low in HDR.
//
// Buffer ownership: one slot is always left empty so rd == wr means empty.
// A write to the slot at the read pointer is never made, and the eop word is
// refused when it would leave the next header slot equal to the read pointer.
module mac_rx_frame_writer
    import mac_rx_wr_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 384
) (
    input  logic              mac_clk_i,
    input  logic              mac_rst_i,
    input  logic              mac_rxda_i,
    output logic              mac_rxrqrd_o,
    input  logic [31:0]       mac_rxd_i,
    input  logic [1:0]        mac_ben_i,
    input  logic              mac_rxsop_i,
    input  logic              mac_rxeop_i,
    input  logic              mac_rxdv_i,
    output logic              buf_we_o,
    output logic [ADDR_W-1:0] buf_waddr_o,
    output logic [31:0]       buf_wdata_o,
    input  logic [ADDR_W-1:0] buf_rd_ptr_i,
    output logic [ADDR_W-1:0] buf_wr_ptr_o,
    output logic              frm_done_o,
    output logic              frm_drop_o,
    output state_t            dbg_state_o
`ifdef MAC_RX_WR_DROP_CNT_EN
    ,
    output logic [15:0]       drop_cnt_o
`endif
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO = ADDR_W'(2);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] hdr_ptr_q, hdr_ptr_d;
    logic [ADDR_W-1:0] wd_ptr_q, wd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [15:0]       word_cnt_q, word_cnt_d;
    logic [1:0]        ben_q, ben_d;
    logic              rqrd_q, rqrd_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              drop_q, drop_d;

    logic              start_frame;
    logic [ADDR_W-1:0] free_d;
    logic [ADDR_W-1:0] new_addr, new_next, cont_next;
    logic              blk_new, blk_cont, cnt_full;
    logic [15:0]       hdr_len;
    logic [31:0]       hdr_word;

    // Room checks for the word on the bus, either as the first payload word
    // of a fresh frame (at committed+1) or as a continuation word (at wd_ptr).
    assign new_addr  = wr_ptr_q + ONE;
    assign new_next  = wr_ptr_q + TWO;
    assign cont_next = wd_ptr_q + ONE;
    assign blk_new   = (new_addr == buf_rd_ptr_i) || (mac_rxeop_i && (new_next == buf_rd_ptr_i));
    assign blk_cont  = (wd_ptr_q == buf_rd_ptr_i) || (mac_rxeop_i && (cont_next == buf_rd_ptr_i));
    assign cnt_full  = (word_cnt_q >= 16'(MAX_WORDS));

    // Byte length = 4 per full word plus the bytes of the final word.
    assign hdr_len = ((word_cnt_q - 16'd1) << 2) + ben_to_bytes(ben_q);

    always_comb begin
        hdr_word = '0;
        hdr_word[HDR_LEN_MSB:HDR_LEN_LSB] = hdr_len;
    end

    always_comb begin
        state_d     = state_q;
        hdr_ptr_d   = hdr_ptr_q;
        wd_ptr_d    = wd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        word_cnt_d  = word_cnt_q;
        ben_d       = ben_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        done_d      = 1'b0;
        drop_d      = 1'b0;
        rqrd_d      = 1'b0;
        start_frame = 1'b0;
        free_d      = '0;

        unique case (state_q)
            IDLE: begin
                // Words without sop in IDLE are stray and ignored.
                if (mac_rxdv_i && mac_rxsop_i) begin
                    start_frame = 1'b1;
                end
            end
            RECV: begin
                if (mac_rxdv_i) begin
                    if (mac_rxsop_i) begin
                        // Truncated frame: discard it and restart at the
                        // committed pointer with this word.
                        drop_d      = 1'b1;
                        start_frame = 1'b1;
                    end else if (cnt_full || blk_cont) begin
                        if (mac_rxeop_i) begin
                            drop_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = DROP;
                        end
                    end else begin
                        we_d       = 1'b1;
                        waddr_d    = wd_ptr_q;
                        wdata_d    = mac_rxd_i;
                        wd_ptr_d   = cont_next;
                        word_cnt_d = word_cnt_q + 16'd1;
                        ben_d      = mac_ben_i;
                        if (mac_rxeop_i) begin
                            state_d = HDR;
                        end
                    end
                end
            end
            HDR: begin
                we_d     = 1'b1;
                waddr_d  = hdr_ptr_q;
                wdata_d  = hdr_word;
                wr_ptr_d = wd_ptr_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            DROP: begin
                if (mac_rxdv_i && mac_rxeop_i) begin
                    drop_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_frame) begin
            hdr_ptr_d = wr_ptr_q;
            if (blk_new) begin
                if (mac_rxeop_i) begin
                    drop_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = DROP;
                end
            end else begin
                we_d       = 1'b1;
                waddr_d    = new_addr;
                wdata_d    = mac_rxd_i;
                wd_ptr_d   = new_next;
                word_cnt_d = 16'd1;
                ben_d      = mac_ben_i;
                state_d    = mac_rxeop_i ? HDR : RECV;
            end
        end

        // Request is registered, so it is derived from the next state and
        // the next committed pointer.
        free_d = buf_rd_ptr_i - wr_ptr_d - ONE;
        unique case (state_d)
            IDLE:       rqrd_d = mac_rxda_i && (free_d >= TWO);
            RECV, DROP: rqrd_d = 1'b1;
            default:    rqrd_d = 1'b0;
        endcase
    end

    always_ff @(posedge mac_clk_i) begin
        if (mac_rst_i) begin
            state_q    <= IDLE;
            hdr_ptr_q  <= '0;
            wd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            word_cnt_q <= '0;
            ben_q      <= '0;
            rqrd_q     <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hdr_ptr_q  <= hdr_ptr_d;
            wd_ptr_q   <= wd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            word_cnt_q <= word_cnt_d;
            ben_q      <= ben_d;
            rqrd_q     <= rqrd_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            drop_q     <= drop_d;
        end
    end

    assign mac_rxrqrd_o = rqrd_q;
    assign buf_we_o     = we_q;
    assign buf_waddr_o  = waddr_q;
    assign buf_wdata_o  = wdata_q;
    assign buf_wr_ptr_o = wr_ptr_q;
    assign frm_done_o   = done_q;
    assign frm_drop_o   = drop_q;
    assign dbg_state_o  = state_q;

`ifdef MAC_RX_WR_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_q && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge mac_clk_i) begin
        if (mac_rst_i) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`endif

endmodule
